// File: rtl/pair_pkg.sv
// Shared types and constants for the pair packer datapath.
package pair_pkg;

  localparam int PAIR_W = 2;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } pk_state_t;

  // A pair count runs 0..word_pairs inclusive, so it needs one bit above log2.
  function automatic int count_width(input int word_pairs);
    return $clog2(word_pairs) + 1;
  endfunction

endpackage

// File: rtl/pair_packer_word_fifo.sv
// First-word-fall-through FIFO holding completed {word, count} entries.
module word_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head is presented while empty only as zero, so a drained FIFO reads back clean.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; a push and pop on a full FIFO leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pair_packer.sv
// Packs a stream of 2-bit {q,w} pairs into words, with flush of partial words.
module pair_packer
  import pair_pkg::*;
#(
  parameter  int WORD_PAIRS = 4,
  parameter  int FIFO_DEPTH = 2,
  localparam int W          = PAIR_W * WORD_PAIRS,
  localparam int CW         = count_width(WORD_PAIRS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [1:0]    in_data,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_count,
  input  logic          out_ready
);

  pk_state_t      state, state_nxt;
  logic [W-1:0]   acc, acc_w, acc_nxt;
  logic [CW-1:0]  cnt, cnt_w, cnt_nxt;
  logic           accept;
  logic           complete;
  logic           can_push;
  logic           push;
  logic [W+CW-1:0] push_word;
  logic [W+CW-1:0] head_word;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  assign in_ready  = (state == FILL) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees the slot a full FIFO would otherwise refuse.
  assign can_push  = !fifo_full || pop;
  assign out_data  = head_word[W+CW-1:CW];
  assign out_count = head_word[CW-1:0];

  // Next-state and push decision; the accumulator view includes any pair accepted this cycle.
  always_comb begin
    acc_w     = acc;
    cnt_w     = cnt;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    state_nxt = state;
    complete  = 1'b0;
    push      = 1'b0;
    push_word = {acc, cnt};
    if (accept) begin
      for (int k = 0; k < WORD_PAIRS; k++) begin
        if (cnt == CW'(k)) acc_w[PAIR_W*k +: PAIR_W] = in_data;
      end
      cnt_w = cnt + CW'(1);
    end
    case (state)
      FILL: begin
        complete = (cnt_w == CW'(WORD_PAIRS)) || (flush && (cnt_w != '0));
        if (complete && can_push) begin
          push      = 1'b1;
          push_word = {acc_w, cnt_w};
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          acc_nxt = acc_w;
          cnt_nxt = cnt_w;
          if (complete) state_nxt = STALL;
        end
      end
      STALL: begin
        if (can_push) begin
          push      = 1'b1;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Assembler state register; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  word_fifo #(
    .WIDTH (W + CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
